// File: rtl/character_motion_if.sv
// character_motion_if: key/pause inputs and sprite state outputs
// shared between game control and the sprite motion block.
interface character_motion_if #(
  parameter int W = 10
);
  logic [7:0]   keycode;
  logic         pause;
  logic [W-1:0] CharX;
  logic [W-1:0] CharY;
  logic [W-1:0] CharS;
  logic [1:0]   Dir;
  logic         Moving;
  logic         Blocked;

  modport master (
    output keycode,
    output pause,
    input  CharX,
    input  CharY,
    input  CharS,
    input  Dir,
    input  Moving,
    input  Blocked
  );

  modport slave (
    input  keycode,
    input  pause,
    output CharX,
    output CharY,
    output CharS,
    output Dir,
    output Moving,
    output Blocked
  );
endinterface

// File: rtl/character_motion.sv
// character_motion: WASD sprite motion with held-key speed ramp and
// playfield clamp; position follows the key on the same frame edge.
module character_motion #(
  parameter int W            = 10,
  parameter int X_CENTER     = 280,
  parameter int Y_CENTER     = 334,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int SIZE         = 4,
  parameter int STEP         = 1,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic frame_clk,
  input  logic Reset,
  character_motion_if.slave bus
);

  localparam int SW = W + 2;
  localparam int W1 = W + 1;
  localparam int HW =
    (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [W-1:0]  STEP_V    = W'(STEP);
  localparam logic [W:0]    STEP_W    = W1'(STEP);
  localparam logic [W:0]    MAX_V     = W1'(MAX_SPEED);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_FRAMES - 1);

  localparam logic signed [SW-1:0] X_LO = SW'(X_MIN + SIZE);
  localparam logic signed [SW-1:0] X_HI = SW'(X_MAX - SIZE);
  localparam logic signed [SW-1:0] Y_LO = SW'(Y_MIN + SIZE);
  localparam logic signed [SW-1:0] Y_HI = SW'(Y_MAX - SIZE);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    PAUSED
  } state_t;

  state_t state;
  state_t f_state;

  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [1:0]    dir;
  logic [W-1:0]  spd;
  logic [HW-1:0] hold;
  logic          moving;
  logic          blocked;

  logic          key_hit;
  logic [1:0]    key_dir;

  logic [1:0]    f_dir;
  logic [W-1:0]  f_spd;
  logic [HW-1:0] f_hold;
  logic          go;
  logic [W:0]    ramp;

  logic          horiz;
  logic          neg;
  logic [W-1:0]  cur;
  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] dlt;
  logic signed [SW-1:0] tgt;
  logic signed [SW-1:0] lo;
  logic signed [SW-1:0] hi;
  logic [W-1:0]  res;

  logic [W-1:0]  n_x;
  logic [W-1:0]  n_y;
  logic [W-1:0]  n_spd;
  logic [HW-1:0] n_hold;
  logic          n_blk;

  always_comb begin
    key_hit = 1'b1;
    key_dir = 2'd0;
    unique case (1'b1)
      bus.keycode == 8'h07: key_dir = 2'd0;
      bus.keycode == 8'h04: key_dir = 2'd1;
      bus.keycode == 8'h16: key_dir = 2'd2;
      bus.keycode == 8'h1A: key_dir = 2'd3;
      default:              key_hit = 1'b0;
    endcase
  end

  assign ramp = {1'b0, spd} + STEP_W;

  // Mode, direction and speed choice before any edge clamp.
  always_comb begin
    f_state = state;
    f_dir   = dir;
    f_spd   = spd;
    f_hold  = hold;
    go      = 1'b0;
    if (bus.pause) begin
      f_state = PAUSED;
    end else begin
      unique case (state)
        IDLE: begin
          if (key_hit) begin
            f_state = MOVE;
            f_dir   = key_dir;
            f_spd   = STEP_V;
            f_hold  = '0;
            go      = 1'b1;
          end
        end
        MOVE: begin
          if (!key_hit) begin
            f_state = IDLE;
            f_spd   = '0;
            f_hold  = '0;
          end else if (key_dir == dir) begin
            go = 1'b1;
            if (hold == HOLD_LAST) begin
              f_spd  = (ramp > MAX_V) ? MAX_V[W-1:0]
                                      : ramp[W-1:0];
              f_hold = '0;
            end else begin
              f_hold = hold + HW'(1);
            end
          end else begin
            f_dir  = key_dir;
            f_spd  = STEP_V;
            f_hold = '0;
            go     = 1'b1;
          end
        end
        PAUSED: begin
          f_state = IDLE;
          f_spd   = '0;
          f_hold  = '0;
        end
        default: f_state = IDLE;
      endcase
    end
  end

  // Widened signed target so overshoot past either wall never wraps.
  always_comb begin
    horiz  = ~f_dir[1];
    neg    = f_dir[0];
    cur    = horiz ? x : y;
    ext    = $signed({2'b00, cur});
    dlt    = $signed({2'b00, f_spd});
    tgt    = neg ? (ext - dlt) : (ext + dlt);
    lo     = horiz ? X_LO : Y_LO;
    hi     = horiz ? X_HI : Y_HI;
    res    = tgt[W-1:0];
    n_blk  = 1'b0;
    n_spd  = f_spd;
    n_hold = f_hold;
    n_x    = x;
    n_y    = y;
    if (go) begin
      if (tgt < lo) begin
        res   = lo[W-1:0];
        n_blk = 1'b1;
      end else if (tgt > hi) begin
        res   = hi[W-1:0];
        n_blk = 1'b1;
      end
      if (n_blk) begin
        n_spd  = STEP_V;
        n_hold = '0;
      end
      if (horiz) n_x = res;
      else       n_y = res;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      x       <= W'(X_CENTER);
      y       <= W'(Y_CENTER);
      dir     <= 2'd0;
      spd     <= '0;
      hold    <= '0;
      moving  <= 1'b0;
      blocked <= 1'b0;
    end else begin
      state   <= f_state;
      x       <= n_x;
      y       <= n_y;
      dir     <= f_dir;
      spd     <= n_spd;
      hold    <= n_hold;
      moving  <= (n_x != x) || (n_y != y);
      blocked <= n_blk;
    end
  end

  assign bus.CharX   = x;
  assign bus.CharY   = y;
  assign bus.CharS   = W'(SIZE);
  assign bus.Dir     = dir;
  assign bus.Moving  = moving;
  assign bus.Blocked = blocked;

endmodule

// File: tb/tb_character_motion.sv
// tb_character_motion: scoreboard bench with a frame-level reference
// model, directed scenarios and randomized key/pause traffic.
module tb_character_motion;

  localparam int XC = 280;
  localparam int YC = 334;
  localparam int XLO = 0 + 4;
  localparam int XHI = 639 - 4;
  localparam int YLO = 0 + 4;
  localparam int YHI = 479 - 4;
  localparam int STEP = 1;
  localparam int MAXS = 4;
  localparam int ACC = 4;

  typedef struct {
    int x;
    int y;
    int dir;
    int mv;
    int blk;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  int m_x, m_y, m_dir, m_spd, m_hold;
  bit m_active, m_paused;

  character_motion_if #(.W(10)) bus ();

  character_motion #(.W(10)) dut (
    .frame_clk (clk),
    .Reset     (rst),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_x = XC; m_y = YC; m_dir = 0; m_spd = 0; m_hold = 0;
    m_active = 0; m_paused = 0;
  endtask

  // One frame of the game rules, applied to the model state.
  task automatic model_step(input logic [7:0] k, input bit p,
                            output exp_t e);
    int kd, ox, oy, t, lo, hi, blk;
    bit hit;
    ox = m_x; oy = m_y; blk = 0; hit = 1; kd = 0; t = 0;
    case (k)
      8'h07: kd = 0;
      8'h04: kd = 1;
      8'h16: kd = 2;
      8'h1A: kd = 3;
      default: hit = 0;
    endcase
    if (p) begin
      m_paused = 1;
    end else if (m_paused) begin
      m_paused = 0; m_active = 0; m_spd = 0; m_hold = 0;
    end else if (!hit) begin
      m_active = 0; m_spd = 0; m_hold = 0;
    end else begin
      if (!m_active || kd != m_dir) begin
        m_dir = kd; m_spd = STEP; m_hold = 0;
      end else if (m_hold == ACC - 1) begin
        m_spd = (m_spd + STEP > MAXS) ? MAXS : m_spd + STEP;
        m_hold = 0;
      end else begin
        m_hold++;
      end
      m_active = 1;
      if (m_dir < 2) begin
        lo = XLO; hi = XHI;
        t = (m_dir == 1) ? m_x - m_spd : m_x + m_spd;
      end else begin
        lo = YLO; hi = YHI;
        t = (m_dir == 3) ? m_y - m_spd : m_y + m_spd;
      end
      if (t < lo) begin t = lo; blk = 1; end
      else if (t > hi) begin t = hi; blk = 1; end
      if (blk != 0) begin m_spd = STEP; m_hold = 0; end
      if (m_dir < 2) m_x = t;
      else m_y = t;
    end
    e.x = m_x; e.y = m_y; e.dir = m_dir;
    e.mv = (m_x != ox || m_y != oy) ? 1 : 0;
    e.blk = blk;
  endtask

  // Returns 3 time units after the edge that consumed the inputs.
  task automatic drive(input logic [7:0] k, input bit p);
    exp_t e;
    @(negedge clk);
    bus.keycode = k;
    bus.pause   = p;
    model_step(k, p, e);
    exp_q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  task automatic chk_reset_vals();
    chk("rst_x", int'(bus.CharX), XC);
    chk("rst_y", int'(bus.CharY), YC);
    chk("rst_dir", int'(bus.Dir), 0);
    chk("rst_mv", int'(bus.Moving), 0);
    chk("rst_blk", int'(bus.Blocked), 0);
  endtask

  // Asynchronous pulse well away from either clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset_vals();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("x", int'(bus.CharX), e.x);
        chk("y", int'(bus.CharY), e.y);
        chk("dir", int'(bus.Dir), e.dir);
        chk("moving", int'(bus.Moving), e.mv);
        chk("blocked", int'(bus.Blocked), e.blk);
      end
    end
  end

  initial begin : stim
    int t2[5];
    int ys[4];
    int bs[4];
    int ms[4];
    logic [7:0] keys[7];
    logic [7:0] k;
    bit p;
    t2 = '{281, 282, 283, 284, 286};
    ys = '{5, 4, 4, 4};
    bs = '{0, 0, 1, 1};
    ms = '{1, 1, 0, 0};
    keys = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h00, 8'h2C, 8'h00};
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.keycode = 8'h00;
    bus.pause = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals();
    chk("chars", int'(bus.CharS), 4);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(8'h07, 0);
      chk("t2_x", int'(bus.CharX), t2[i]);
    end
    chk("t2_dir", int'(bus.Dir), 0);
    chk("t2_mv", int'(bus.Moving), 1);

    do_reset();
    for (int i = 0; i < 17; i++) drive(8'h07, 0);
    chk("t3_x", int'(bus.CharX), 324);
    for (int i = 0; i < 4; i++) drive(8'h00, 0);
    chk("t3_hold", int'(bus.CharX), 324);
    chk("t3_mv", int'(bus.Moving), 0);

    do_reset();
    for (int i = 0; i < 9; i++) drive(8'h07, 0);
    chk("t4_pre", int'(bus.CharX), 295);
    drive(8'h04, 0);
    chk("t4_x", int'(bus.CharX), 294);
    chk("t4_dir", int'(bus.Dir), 1);

    do_reset();
    for (int i = 0; i < 200; i++) drive(8'h1A, 0);
    chk("t5_top", int'(bus.CharY), YLO);
    drive(8'h16, 0);
    drive(8'h16, 0);
    drive(8'h00, 0);
    chk("t5_y6", int'(bus.CharY), 6);
    for (int i = 0; i < 4; i++) begin
      drive(8'h1A, 0);
      chk("t5_y", int'(bus.CharY), ys[i]);
      chk("t5_blk", int'(bus.Blocked), bs[i]);
      chk("t5_mv", int'(bus.Moving), ms[i]);
    end
    for (int i = 0; i < 250; i++) drive(8'h07, 0);
    chk("t5_xr", int'(bus.CharX), XHI);
    chk("t5_xblk", int'(bus.Blocked), 1);

    do_reset();
    for (int i = 0; i < 5; i++) drive(8'h07, 0);
    for (int i = 0; i < 10; i++) begin
      drive(8'h07, 1);
      chk("t6_frz", int'(bus.CharX), 286);
    end
    drive(8'h07, 0);
    drive(8'h07, 0);
    chk("t6_rel", int'(bus.CharX), 287);
    for (int i = 0; i < 5; i++) drive(8'h2C, 0);
    chk("t6_oth", int'(bus.CharX), 287);
    chk("t6_omv", int'(bus.Moving), 0);

    do_reset();
    k = 8'h00;
    p = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        k = keys[$urandom_range(0, 6)];
        if ($urandom_range(0, 6) == 6) k = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 99) < 4) p = ~p;
      drive(k, p);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    repeat (3) @(posedge clk);
    #3;
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
